// File: rtl/spmv_sched_pkg.sv
// rtl/spmv_sched_pkg.sv - shared state encoding and widths for the SpMV row scheduler
package spmv_sched_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int BEAT_W    = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_FIRST,
        S_ROWS,
        S_DRAIN,
        S_DONE
    } state_e;

endpackage

// File: rtl/spmv_row_scheduler_if.sv
// rtl/spmv_row_scheduler_if.sv - row-pointer in, TIMES out, Xi read command and kernel beat monitor
interface spmv_row_scheduler_if
    import spmv_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic [CNT_W-1:0] s_rowptr_tdata;
    logic             s_rowptr_tvalid;
    logic             s_rowptr_tready;
    logic [CNT_W-1:0] m_times_tdata;
    logic             m_times_tvalid;
    logic             m_times_tready;
    logic             read_begin;
    logic [CNT_W-1:0] read_length;
    logic             kout_valid;
    logic             kout_ready;

    modport master (
        input  s_rowptr_tdata, s_rowptr_tvalid,
        output s_rowptr_tready,
        output m_times_tdata, m_times_tvalid,
        input  m_times_tready,
        output read_begin, read_length,
        input  kout_valid, kout_ready
    );

    modport slave (
        output s_rowptr_tdata, s_rowptr_tvalid,
        input  s_rowptr_tready,
        input  m_times_tdata, m_times_tvalid,
        output m_times_tready,
        input  read_begin, read_length,
        output kout_valid, kout_ready
    );

endinterface

// File: rtl/spmv_row_scheduler.sv
// rtl/spmv_row_scheduler.sv - turns CSR row pointers into per-row NNZ counts and tracks pass completion
module spmv_row_scheduler
    import spmv_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [CNT_W-1:0] num_rows,
    input  logic [CNT_W-1:0] nnz_total,
    input  logic [CNT_W-1:0] expected_beats,
    spmv_row_scheduler_if.master bus,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] rows_issued
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] num_rows_q, num_rows_d;
    logic [CNT_W-1:0] nnz_q, nnz_d;
    logic [CNT_W-1:0] exp_beats_q, exp_beats_d;
    logic [CNT_W-1:0] prev_q, prev_d;
    logic [CNT_W-1:0] base_q, base_d;
    logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] rows_issued_q, rows_issued_d;
    logic [CNT_W-1:0] times_data_q, times_data_d;
    logic             times_valid_q, times_valid_d;
    logic             error_q, error_d;

    logic rowptr_ready;
    logic ptr_fire;
    logic times_fire;
    logic beat_fire;

    always_comb begin
        rowptr_ready = (state_q == S_FIRST) ||
                       ((state_q == S_ROWS) && (!times_valid_q || bus.m_times_tready));
        ptr_fire     = rowptr_ready && bus.s_rowptr_tvalid;
        times_fire   = times_valid_q && bus.m_times_tready;
        beat_fire    = bus.kout_valid && bus.kout_ready;
    end

    always_comb begin
        state_d       = state_q;
        num_rows_d    = num_rows_q;
        nnz_d         = nnz_q;
        exp_beats_d   = exp_beats_q;
        prev_d        = prev_q;
        base_d        = base_q;
        row_cnt_d     = row_cnt_q;
        beat_cnt_d    = beat_cnt_q;
        rows_issued_d = rows_issued_q;
        times_data_d  = times_data_q;
        times_valid_d = times_valid_q;
        error_d       = error_q;

        if (times_fire) begin
            times_valid_d = 1'b0;
            rows_issued_d = rows_issued_q + ONE;
        end

        // Any beat past the expected count means the kernel over-produced.
        if ((state_q != S_IDLE) && beat_fire) begin
            if (beat_cnt_q >= exp_beats_q) error_d = 1'b1;
            if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + ONE;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_rows_d    = num_rows;
                    nnz_d         = nnz_total;
                    exp_beats_d   = expected_beats;
                    prev_d        = '0;
                    base_d        = '0;
                    row_cnt_d     = '0;
                    beat_cnt_d    = '0;
                    rows_issued_d = '0;
                    error_d       = 1'b0;
                    if (num_rows == '0) begin
                        error_d = (nnz_total != '0);
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CMD;
                    end
                end
            end
            S_CMD: state_d = S_FIRST;
            S_FIRST: begin
                if (ptr_fire) begin
                    prev_d  = bus.s_rowptr_tdata;
                    base_d  = bus.s_rowptr_tdata;
                    state_d = S_ROWS;
                end
            end
            S_ROWS: begin
                if (ptr_fire) begin
                    if (bus.s_rowptr_tdata >= prev_q) begin
                        times_data_d = bus.s_rowptr_tdata - prev_q;
                    end else begin
                        times_data_d = '0;
                        error_d      = 1'b1;
                    end
                    times_valid_d = 1'b1;
                    prev_d        = bus.s_rowptr_tdata;
                    row_cnt_d     = row_cnt_q + ONE;
                    if (row_cnt_q + ONE == num_rows_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Look ahead at this cycle's handshakes so a coincident last beat costs no extra cycle.
                if ((!times_valid_q || bus.m_times_tready) && (beat_cnt_d >= exp_beats_q)) begin
                    if (prev_q - base_q != nnz_q) error_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            num_rows_q    <= '0;
            nnz_q         <= '0;
            exp_beats_q   <= '0;
            prev_q        <= '0;
            base_q        <= '0;
            row_cnt_q     <= '0;
            beat_cnt_q    <= '0;
            rows_issued_q <= '0;
            times_data_q  <= '0;
            times_valid_q <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            num_rows_q    <= num_rows_d;
            nnz_q         <= nnz_d;
            exp_beats_q   <= exp_beats_d;
            prev_q        <= prev_d;
            base_q        <= base_d;
            row_cnt_q     <= row_cnt_d;
            beat_cnt_q    <= beat_cnt_d;
            rows_issued_q <= rows_issued_d;
            times_data_q  <= times_data_d;
            times_valid_q <= times_valid_d;
            error_q       <= error_d;
        end
    end

    assign bus.s_rowptr_tready = rowptr_ready;
    assign bus.m_times_tdata   = times_data_q;
    assign bus.m_times_tvalid  = times_valid_q;
    assign bus.read_begin      = (state_q == S_CMD);
    assign bus.read_length     = nnz_q;

    assign busy        = (state_q == S_CMD) || (state_q == S_FIRST) ||
                         (state_q == S_ROWS) || (state_q == S_DRAIN);
    assign done        = (state_q == S_DONE);
    assign error       = error_q;
    assign rows_issued = rows_issued_q;

endmodule

// File: tb/tb_spmv_row_scheduler.sv
// tb/tb_spmv_row_scheduler.sv - scoreboard bench for the SpMV row scheduler
module tb_spmv_row_scheduler;
    import spmv_sched_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic         start = 1'b0;
    logic [W-1:0] num_rows = '0, nnz_total = '0, expected_beats = '0;
    logic         busy, done, error;
    logic [W-1:0] rows_issued;

    spmv_row_scheduler_if #(.CNT_W(W)) bus ();

    spmv_row_scheduler #(.CNT_W(W)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .start          (start),
        .num_rows       (num_rows),
        .nnz_total      (nnz_total),
        .expected_beats (expected_beats),
        .bus            (bus),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .rows_issued    (rows_issued)
    );

    typedef struct {
        logic         err;
        logic [W-1:0] rows;
    } done_t;

    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] times_q[$];
    logic [W-1:0] rb_q[$];
    logic [W-1:0] ptr_q[$];
    done_t        done_q[$];
    bit           no_ready = 0;
    bit           tog = 0;
    logic         hold_v = 1'b0;
    logic [W-1:0] hold_d = '0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got an event, required none", name);
    endtask

    always @(negedge clk) begin
        done_t d;
        if (rstn) begin
            if (bus.read_begin) begin
                if (rb_q.size() == 0) unexpected("read_begin");
                else chk("read_length", bus.read_length, rb_q.pop_front());
            end
            if (bus.m_times_tvalid && bus.m_times_tready) begin
                if (times_q.size() == 0) unexpected("times_beat");
                else chk("times_data", bus.m_times_tdata, times_q.pop_front());
            end
            if (hold_v) begin
                chk("times_valid_held", bus.m_times_tvalid, 1);
                chk("times_data_held", bus.m_times_tdata, hold_d);
            end
            if (bus.m_times_tvalid && !bus.m_times_tready)
                chk("rowptr_ready_when_full", bus.s_rowptr_tready, 0);
            if (no_ready) chk("rowptr_ready_idle", bus.s_rowptr_tready, 0);
            if (done) begin
                if (done_q.size() == 0) unexpected("done");
                else begin
                    d = done_q.pop_front();
                    chk("error_at_done", error, d.err);
                    chk("rows_issued_at_done", rows_issued, d.rows);
                    chk("busy_at_done", busy, 0);
                end
            end
            hold_v <= bus.m_times_tvalid && !bus.m_times_tready;
            hold_d <= bus.m_times_tdata;
        end else begin
            hold_v <= 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (tog) bus.m_times_tready = ~bus.m_times_tready;
    end

    task automatic do_start(input logic [W-1:0] nr, input logic [W-1:0] nnz, input logic [W-1:0] eb);
        @(posedge clk); #1;
        num_rows = nr; nnz_total = nnz; expected_beats = eb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_ptrs();
        int n = 0;
        while (ptr_q.size() > 0 && n < 200) begin
            bus.s_rowptr_tdata  = ptr_q[0];
            bus.s_rowptr_tvalid = 1'b1;
            @(negedge clk);
            if (bus.s_rowptr_tready) void'(ptr_q.pop_front());
            @(posedge clk); #1;
            n++;
        end
        bus.s_rowptr_tvalid = 1'b0;
        chk("ptrs_all_accepted", ptr_q.size(), 0);
    endtask

    task automatic give_beats(input int n);
        for (int i = 0; i < n; i++) begin
            bus.kout_valid = 1'b1; bus.kout_ready = 1'b1;
            @(posedge clk); #1;
            bus.kout_valid = 1'b0; bus.kout_ready = 1'b0;
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s: done not seen within %0d cycles, required done", name, budget);
        end
        @(posedge clk); #1;
    endtask

    task automatic end_check(input string tag);
        chk({tag, "_times_left"}, times_q.size(), 0);
        chk({tag, "_read_begin_left"}, rb_q.size(), 0);
        chk({tag, "_done_left"}, done_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rowptr_tready"}, bus.s_rowptr_tready, 0);
        chk({tag, "_times_tvalid"}, bus.m_times_tvalid, 0);
        chk({tag, "_times_tdata"}, bus.m_times_tdata, 0);
        chk({tag, "_read_begin"}, bus.read_begin, 0);
        chk({tag, "_read_length"}, bus.read_length, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_rows_issued"}, rows_issued, 0);
    endtask

    task automatic basic_pass(input string tag);
        ptr_q = '{32'd0, 32'd2, 32'd2, 32'd7};
        times_q = '{32'd2, 32'd0, 32'd5};
        rb_q.push_back(32'd7);
        done_q.push_back('{1'b0, 32'd3});
        do_start(3, 7, 1);
        send_ptrs();
        give_beats(1);
        wait_done(tag, 20);
        end_check(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_rowptr_tdata = '0; bus.s_rowptr_tvalid = 1'b0;
        bus.m_times_tready = 1'b1; bus.kout_valid = 1'b0; bus.kout_ready = 1'b0;
        #12;
        check_reset_outputs("reset");
        rstn = 1'b1;

        basic_pass("t1");

        tog = 1;
        basic_pass("t2_toggle");
        tog = 0;
        @(posedge clk); #1;
        bus.m_times_tready = 1'b1;

        ptr_q = '{32'd0, 32'd5, 32'd3};
        times_q = '{32'd5, 32'd0};
        rb_q.push_back(32'd3);
        done_q.push_back('{1'b1, 32'd2});
        do_start(2, 3, 0);
        send_ptrs();
        wait_done("t3_descending", 20);
        end_check("t3");

        no_ready = 1;
        done_q.push_back('{1'b0, 32'd0});
        do_start(0, 0, 0);
        wait_done("t4_zero_rows", 2);
        done_q.push_back('{1'b1, 32'd0});
        do_start(0, 5, 0);
        wait_done("t4_zero_rows_nnz", 2);
        no_ready = 0;
        end_check("t4");

        ptr_q = '{32'd0, 32'd2, 32'd2, 32'd7};
        times_q = '{32'd2, 32'd0, 32'd5};
        rb_q.push_back(32'd7);
        done_q.push_back('{1'b0, 32'd3});
        do_start(3, 7, 2);
        send_ptrs();
        give_beats(1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t5_busy_waiting", busy, 1);
            chk("t5_no_done_waiting", done, 0);
            @(posedge clk); #1;
        end
        give_beats(1);
        @(negedge clk);
        chk("t5_done_after_last_beat", done, 1);
        @(posedge clk); #1;
        end_check("t5");

        ptr_q = '{32'd0, 32'd4};
        times_q = '{32'd4};
        rb_q.push_back(32'd4);
        done_q.push_back('{1'b1, 32'd1});
        do_start(1, 4, 0);
        give_beats(1);
        send_ptrs();
        wait_done("t6_extra_beat", 20);
        end_check("t6");

        ptr_q = '{32'd0, 32'd2};
        times_q = '{32'd2};
        rb_q.push_back(32'd7);
        do_start(3, 7, 1);
        send_ptrs();
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("midpass_reset");
        times_q.delete(); rb_q.delete(); done_q.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        basic_pass("t7_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
